matrix_op_scheduler: RTL and testbench
======================================

MATRIX_OP_SCHEDULER -- requirements
Module: matrix_op_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles an engine may run before abort (>=2).
REQ-002 SHALL have parameter TW, default 16, width of the timeout counter; TIMEOUT_CYCLES SHALL fit in TW bits.
REQ-003 SHALL provide inout vccd1 and vssd1 supply pins, present only under USE_POWER_PINS.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0, req1  input  1 each  level request from requester 0/1, held until ack.
REQ-007 op0, op1  input  2 each  requested operation: 2'b01 multiply, 2'b10 convolution, other values illegal.
REQ-008 ack0, ack1  output  1 each  one-cycle pulse: request accepted.
REQ-009 done0, done1  output  1 each  one-cycle pulse: owner's operation complete.
REQ-010 err  output  1  valid with doneN: 1 = illegal op or timeout, 0 = success.
REQ-011 matrix_mult_done, matrix_conv_done  input  1 each  engine completion levels.
REQ-012 multiplier_enable, convolution_enable  output  1 each  engine enables, at most one high.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 owner  output  1  index of the requester currently served; holds the last served index in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, REPORT; all outputs registered.
REQ-016 In IDLE with any req high, SHALL grant one requester: if both request, grant the requester not served last (round-robin); after reset requester 0 wins.
REQ-017 On grant edge, SHALL latch the op and owner, pulse ackN for exactly the next cycle, and clear the timeout counter.
REQ-018 Granted legal op: next state RUN; the matching enable SHALL rise in the same cycle as ackN.
REQ-019 Granted illegal op: next state REPORT with err=1; no enable SHALL assert.
REQ-020 In RUN, the counter SHALL increment every cycle; the selected engine's done SHALL be sampled and the other engine's done ignored.
REQ-021 In RUN, the selected done high -> enable low and state REPORT with err=0 on the next cycle.
REQ-022 In RUN, counter == TIMEOUT_CYCLES-1 with done low -> enable low, REPORT, err=1; if done and timeout coincide, done wins (err=0).
REQ-023 REPORT SHALL last exactly one cycle: doneN=1 for the owner only, err valid, then IDLE.
REQ-024 Requests SHALL NOT be sampled outside IDLE, so the minimum spacing between acks is 3 cycles (grant, RUN >=1, REPORT).
REQ-025 err SHALL be 0 whenever done0 and done1 are both 0.
REQ-026 A requester dropping reqN before ack SHALL simply not be granted; no state change.

Reset
REQ-027 While reset is high, SHALL force IDLE and clear ack0, ack1, done0, done1, err, busy, owner, multiplier_enable, convolution_enable, the counter and the round-robin pointer; reset overrides all other events.
REQ-028 Reset during RUN SHALL drop the enable on the next edge; no doneN SHALL be produced for the aborted op.

Structure
REQ-029 Op codes (2'b01, 2'b10) and state encodings SHALL be defined as shared `define constants in the project definitions include, alongside the MULTIPLICATION_OPERATION and CONVOLUTION_OPERATION constants.
REQ-030 The round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs: req[1:0], last; output: grant[1:0], one-hot or zero).

Verification
REQ-031 req0=1, op0=01; matrix_mult_done raised 5 cycles after ack0 -> multiplier_enable high for 6 cycles; done0 pulse; err=0.
REQ-032 req0 and req1 high in the same cycle after reset, both op=10 -> ack0 first; ack1 exactly 1 cycle after done0; done1 follows.
REQ-033 TIMEOUT_CYCLES=8, op=01, matrix_mult_done held low -> enable high for 8 cycles; done with err=1.
REQ-034 op1=11 -> ack1, then done1 with err=1 on the next cycle; both enables stay 0 throughout.
REQ-035 Reset pulsed 2 cycles into RUN -> enable low on the next edge; no doneN; busy=0.
REQ-036 op=01 with matrix_conv_done high during RUN -> ignored; completion occurs only on matrix_mult_done.

Source files
------------

// File: rtl/matrix_op_scheduler_pkg.sv
// Shared op codes, state encodings and helpers for the matrix operation scheduler.
`ifndef MATRIX_OP_SCHEDULER_DEFS
`define MATRIX_OP_SCHEDULER_DEFS
`define MULTIPLICATION_OPERATION 2'b01
`define CONVOLUTION_OPERATION    2'b10
`define OP_MULTIPLY              `MULTIPLICATION_OPERATION
`define OP_CONVOLUTION           `CONVOLUTION_OPERATION
`define MOS_STATE_IDLE           2'b00
`define MOS_STATE_RUN            2'b01
`define MOS_STATE_REPORT         2'b10
`endif

package matrix_op_scheduler_pkg;

  localparam logic [1:0] OpMul  = `OP_MULTIPLY;
  localparam logic [1:0] OpConv = `OP_CONVOLUTION;

  typedef enum logic [1:0] {
    StIdle   = `MOS_STATE_IDLE,
    StRun    = `MOS_STATE_RUN,
    StReport = `MOS_STATE_REPORT
  } state_e;

  function automatic logic op_legal(input logic [1:0] op);
    return (op == OpMul) || (op == OpConv);
  endfunction

endpackage

// File: rtl/matrix_op_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the requester not served last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | last);
    grant[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/matrix_op_scheduler.sv
// Arbitrates two requesters onto the multiply/convolution engines, one op at a time,
// with a per-op timeout and a one-cycle completion report.
module matrix_op_scheduler
  import matrix_op_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TW             = 16
) (
`ifdef USE_POWER_PINS
  inout  wire        vccd1,
  inout  wire        vssd1,
`endif
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  input  logic       matrix_mult_done,
  input  logic       matrix_conv_done,
  output logic       multiplier_enable,
  output logic       convolution_enable,
  output logic       busy,
  output logic       owner
);

  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;  // preferred requester on contention
  logic [TW-1:0] cnt_q, cnt_d;
  logic          fail_q, fail_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          err_q, err_d;
  logic          mult_en_q, mult_en_d, conv_en_q, conv_en_d;
  logic          busy_q, busy_d;

  logic [1:0] grant;
  logic [1:0] sel_op;
  logic       sel_done;

  rr_arbiter2 u_arb (
    .req   ({req1, req0}),
    .last  (~rr_q),
    .grant (grant)
  );

  always_comb begin
    sel_op   = grant[1] ? op1 : op0;
    sel_done = (op_q == OpMul) ? matrix_mult_done : matrix_conv_done;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err_d     = 1'b0;
    mult_en_d = mult_en_q;
    conv_en_d = conv_en_q;

    unique case (state_q)
      StIdle: begin
        if (|grant) begin
          owner_d   = grant[1];
          op_d      = sel_op;
          rr_d      = ~grant[1];
          cnt_d     = '0;
          ack0_d    = grant[0];
          ack1_d    = grant[1];
          mult_en_d = (sel_op == OpMul);
          conv_en_d = (sel_op == OpConv);
          fail_d    = ~op_legal(sel_op);
          state_d   = op_legal(sel_op) ? StRun : StReport;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        // Completion takes priority over a coinciding timeout.
        if (sel_done) begin
          mult_en_d = 1'b0;
          conv_en_d = 1'b0;
          fail_d    = 1'b0;
          state_d   = StReport;
        end else if (cnt_q == TimeoutLast) begin
          mult_en_d = 1'b0;
          conv_en_d = 1'b0;
          fail_d    = 1'b1;
          state_d   = StReport;
        end
      end
      StReport: begin
        done0_d = ~owner_q;
        done1_d = owner_q;
        err_d   = fail_q;
        state_d = StIdle;
      end
      default: begin
        mult_en_d = 1'b0;
        conv_en_d = 1'b0;
        state_d   = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= 2'b00;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      fail_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      mult_en_q <= 1'b0;
      conv_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      fail_q    <= fail_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err_q     <= err_d;
      mult_en_q <= mult_en_d;
      conv_en_q <= conv_en_d;
      busy_q    <= busy_d;
    end
  end

  assign ack0               = ack0_q;
  assign ack1               = ack1_q;
  assign done0              = done0_q;
  assign done1              = done1_q;
  assign err                = err_q;
  assign multiplier_enable  = mult_en_q;
  assign convolution_enable = conv_en_q;
  assign busy               = busy_q;
  assign owner              = owner_q;

endmodule

// File: tb/tb_matrix_op_scheduler.sv
// Scoreboard bench: a transaction-level model predicts ack/done events with cycle stamps,
// and a monitor matches every observed pulse against them.
module tb_matrix_op_scheduler;

  localparam int Tmo = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = 2'b00, op1 = 2'b00;
  logic       ack0, ack1, done0, done1, err;
  logic       mdone = 1'b0, cdone = 1'b0;
  logic       mult_en, conv_en, busy, owner;

  matrix_op_scheduler #(
    .TIMEOUT_CYCLES (Tmo),
    .TW             (8)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req0               (req0),
    .req1               (req1),
    .op0                (op0),
    .op1                (op1),
    .ack0               (ack0),
    .ack1               (ack1),
    .done0              (done0),
    .done1              (done1),
    .err                (err),
    .matrix_mult_done   (mdone),
    .matrix_conv_done   (cdone),
    .multiplier_enable  (mult_en),
    .convolution_enable (conv_en),
    .busy               (busy),
    .owner              (owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    bit who;
    bit err;
    int cyc;
    int n_mult;
    int n_conv;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  bit  rr_p = 1'b0;  // model: requester that wins a tie

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, want);
    end
  endtask

  function automatic bit legal(input logic [1:0] op);
    return (op == 2'b01) || (op == 2'b10);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req0 = 1'b0; req1 = 1'b0; mdone = 1'b0; cdone = 1'b0;
    repeat (n) step();
  endtask

  // One arbitration round; DUT is idle at the current cycle.
  task automatic run_round(input int mask, input logic [1:0] opa, input logic [1:0] opb,
                           input int da, input int db, input bit noise);
    int E, ns, t;
    int who[2], ack[2], dn[2], dl[2];
    logic [1:0] op[2];
    logic [1:0] rq;
    ev_t e;
    E = cyc;
    if (mask == 3) begin
      ns = 2; who[0] = rr_p; who[1] = !rr_p;
    end else begin
      ns = 1; who[0] = (mask == 2) ? 1 : 0; who[1] = 0;
    end
    t = E + 1;
    for (int k = 0; k < ns; k++) begin
      op[k]  = (who[k] != 0) ? opb : opa;
      dl[k]  = (who[k] != 0) ? db : da;
      ack[k] = t;
      e = '{is_done: 1'b0, who: who[k][0], err: 1'b0, cyc: t, n_mult: 0, n_conv: 0};
      exp_q.push_back(e);
      e.is_done = 1'b1;
      if (!legal(op[k])) begin
        dn[k] = t + 1; e.err = 1'b1;
      end else if (dl[k] < Tmo) begin
        dn[k] = t + dl[k] + 2; e.err = 1'b0;
        if (op[k] == 2'b01) e.n_mult = dl[k] + 1; else e.n_conv = dl[k] + 1;
      end else begin
        dn[k] = t + Tmo + 1; e.err = 1'b1;
        if (op[k] == 2'b01) e.n_mult = Tmo; else e.n_conv = Tmo;
      end
      e.cyc = dn[k];
      exp_q.push_back(e);
      t = dn[k] + 1;
      rr_p = (who[k] == 0);
    end
    for (int c = E; c <= dn[ns-1]; c++) begin
      rq = 2'b00; mdone = 1'b0; cdone = 1'b0;
      op0 = opa; op1 = opb;
      for (int k = 0; k < ns; k++) begin
        if (c < ack[k]) rq[who[k]] = 1'b1;
        if (legal(op[k]) && dl[k] < Tmo && c == ack[k] + dl[k]) begin
          if (op[k] == 2'b01) mdone = 1'b1; else cdone = 1'b1;
        end
        if (noise && legal(op[k]) && c >= ack[k] && c < dn[k]) begin
          if (op[k] == 2'b01) cdone = 1'($urandom_range(0, 1));
          else mdone = 1'($urandom_range(0, 1));
        end
      end
      // Requests raised while busy must be ignored.
      if (ns == 1 && noise && c > ack[0] && c < dn[0])
        rq[!who[0]] = 1'($urandom_range(0, 1));
      req0 = rq[0]; req1 = rq[1];
      step();
    end
    idle(0);
  endtask

  // Monitor: matches every pulse against the scoreboard.
  int n_mult = 0, n_conv = 0;
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        n_mult = 0; n_conv = 0;
      end else begin
        if (mult_en) n_mult++;
        if (conv_en) n_conv++;
        check("enables_exclusive", int'(mult_en & conv_en), 0);
        if (!(done0 | done1)) check("err_without_done", int'(err), 0);
        if (ack0 | ack1 | done0 | done1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", int'({ack0, ack1, done0, done1}), 0);
          end else begin
            e = exp_q.pop_front();
            if (!e.is_done) begin
              check("ack_pulse", int'({ack1, ack0}), e.who ? 2 : 1);
              check("ack_cycle", cyc, e.cyc);
              check("ack_busy", int'(busy), 1);
              check("ack_owner", int'(owner), int'(e.who));
            end else begin
              check("done_pulse", int'({done1, done0}), e.who ? 2 : 1);
              check("done_cycle", cyc, e.cyc);
              check("done_err", int'(err), int'(e.err));
              check("done_busy", int'(busy), 0);
              check("done_owner", int'(owner), int'(e.who));
              check("mult_en_cycles", n_mult, e.n_mult);
              check("conv_en_cycles", n_conv, e.n_conv);
              n_mult = 0; n_conv = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    int a;
    ev_t e;
    repeat (3) step();
    check("rst_ack", int'({ack1, ack0}), 0);
    check("rst_done", int'({done1, done0}), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_owner", int'(owner), 0);
    check("rst_enables", int'({mult_en, conv_en}), 0);
    reset = 1'b0;
    step();

    run_round(3, 2'b10, 2'b10, 2, 3, 1'b0);  // tie after reset: 0 first
    run_round(1, 2'b01, 2'b00, 5, 0, 1'b0);  // 6-cycle multiply
    run_round(2, 2'b00, 2'b11, 0, 0, 1'b0);  // illegal op
    run_round(1, 2'b01, 2'b00, 99, 0, 1'b0); // timeout
    run_round(1, 2'b01, 2'b00, Tmo - 1, 0, 1'b0);  // done coincides with timeout
    run_round(1, 2'b01, 2'b00, 4, 0, 1'b1);  // conv done noise ignored
    run_round(3, 2'b01, 2'b10, 0, 0, 1'b0);  // minimum spacing

    for (int i = 0; i < 60; i++) begin
      logic [1:0] oa, ob;
      int r;
      r  = $urandom_range(0, 7);
      oa = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 5) ? 2'b01 : 2'b10;
      r  = $urandom_range(0, 7);
      ob = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 5) ? 2'b01 : 2'b10;
      run_round($urandom_range(1, 3), oa, ob, $urandom_range(0, 10), $urandom_range(0, 10),
                1'b1);
      idle($urandom_range(0, 2));
    end

    // Reset two cycles into RUN aborts the op silently.
    a = cyc + 1;
    e = '{is_done: 1'b0, who: 1'b0, err: 1'b0, cyc: a, n_mult: 0, n_conv: 0};
    exp_q.push_back(e);
    req0 = 1'b1; op0 = 2'b01;
    step();
    req0 = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    check("abort_enable", int'(mult_en), 0);
    check("abort_busy", int'(busy), 0);
    reset = 1'b0;
    rr_p = 1'b0;
    idle(12);
    run_round(3, 2'b01, 2'b10, 1, 2, 1'b1);  // req0 wins again after reset
    idle(3);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
